// File: rtl/asm_datapath.sv
// Counter datapath for an ASM chart with T0/T1/T2 one-hot control inputs.
// Non-one-hot control cycles are ignored by the datapath and flagged on a sticky ERR.
module asm_datapath #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             S,
    input  logic             T0,
    input  logic             T1,
    input  logic             T2,
    input  logic             ERR_CLR,
    output logic [WIDTH-1:0] A,
    output logic             E,
    output logic             F,
    output logic             Z,
    output logic             X,
    output logic             DONE,
    output logic             ERR,
    output logic [7:0]       CNT
);

    logic [WIDTH-1:0] r_a;
    logic             r_e;
    logic             r_f;
    logic             r_done;
    logic             r_err;
    logic [7:0]       r_cnt;

    logic [WIDTH-1:0] w_a_d;
    logic             w_e_d;
    logic             w_f_d;
    logic             w_done_d;
    logic             w_err_d;
    logic [7:0]       w_cnt_d;

    logic             w_illegal;
    logic             w_start;
    logic             w_inc;
    logic             w_fin;

    assign w_illegal = (T0 & T1) | (T0 & T2) | (T1 & T2);
    assign w_start   = ~w_illegal & T0 & S;
    assign w_inc     = ~w_illegal & T1;
    assign w_fin     = ~w_illegal & T2;

    always_comb begin
        w_a_d    = r_a;
        w_e_d    = r_e;
        w_f_d    = r_f;
        w_cnt_d  = r_cnt;
        w_done_d = 1'b0;

        if (w_start) begin
            w_a_d   = '0;
            w_f_d   = 1'b0;
            w_cnt_d = 8'd0;
        end

        if (w_inc) begin
            // E captures the bit before the increment takes effect
            w_e_d   = r_a[WIDTH-2];
            w_a_d   = r_a + {{(WIDTH-1){1'b0}}, 1'b1};
            w_cnt_d = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
        end

        if (w_fin) begin
            w_f_d    = 1'b1;
            // Pulse only on the 0->1 transition of F
            w_done_d = ~r_f;
        end
    end

    always_comb begin
        w_err_d = r_err;
        if (w_illegal) begin
            w_err_d = 1'b1;
        end else if (ERR_CLR) begin
            w_err_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_a    <= '0;
            r_e    <= 1'b0;
            r_f    <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_cnt  <= 8'd0;
        end else begin
            r_a    <= w_a_d;
            r_e    <= w_e_d;
            r_f    <= w_f_d;
            r_done <= w_done_d;
            r_err  <= w_err_d;
            r_cnt  <= w_cnt_d;
        end
    end

    assign A    = r_a;
    assign E    = r_e;
    assign F    = r_f;
    assign DONE = r_done;
    assign ERR  = r_err;
    assign CNT  = r_cnt;
    assign Z    = r_a[WIDTH-2];
    assign X    = r_a[WIDTH-1];

endmodule

// File: tb/tb_asm_datapath.sv
// Self-checking bench for asm_datapath: vector table, directed corner sequences,
// and randomized control against a plain-arithmetic reference model.
module tb_asm_datapath;

    localparam int W = 4;

    logic         CLK;
    logic         RST;
    logic         S;
    logic         T0;
    logic         T1;
    logic         T2;
    logic         ERR_CLR;
    logic [W-1:0] A;
    logic         E;
    logic         F;
    logic         Z;
    logic         X;
    logic         DONE;
    logic         ERR;
    logic [7:0]   CNT;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_a, m_e, m_f, m_done, m_err, m_cnt;

    asm_datapath #(.WIDTH(W)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .S       (S),
        .T0      (T0),
        .T1      (T1),
        .T2      (T2),
        .ERR_CLR (ERR_CLR),
        .A       (A),
        .E       (E),
        .F       (F),
        .Z       (Z),
        .X       (X),
        .DONE    (DONE),
        .ERR     (ERR),
        .CNT     (CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic t0, t1, t2, s, clr;
        int   a, e, f, done, err, cnt;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int a, input int e, input int f,
                           input int done, input int err, input int cnt);
        chk({tag, " A"}, int'(A), a);
        chk({tag, " E"}, int'(E), e);
        chk({tag, " F"}, int'(F), f);
        chk({tag, " DONE"}, int'(DONE), done);
        chk({tag, " ERR"}, int'(ERR), err);
        chk({tag, " CNT"}, int'(CNT), cnt);
        chk({tag, " Z"}, int'(Z), (a / (2 ** (W - 2))) % 2);
        chk({tag, " X"}, int'(X), (a / (2 ** (W - 1))) % 2);
    endtask

    task automatic chk_model(input string tag);
        chk_all(tag, m_a, m_e, m_f, m_done, m_err, m_cnt);
    endtask

    task automatic model_reset();
        m_a = 0; m_e = 0; m_f = 0; m_done = 0; m_err = 0; m_cnt = 0;
    endtask

    // Apply one cycle of control inputs, clock it, and advance the model.
    task automatic step(input logic t0, input logic t1, input logic t2, input logic s,
                        input logic clr);
        int n;
        T0 = t0; T1 = t1; T2 = t2; S = s; ERR_CLR = clr;
        @(posedge CLK);
        #1;
        n = int'(t0) + int'(t1) + int'(t2);
        m_done = 0;
        if (n >= 2) begin
            m_err = 1;
        end else begin
            if (clr) m_err = 0;
            if (t0 && s) begin
                m_a = 0; m_f = 0; m_cnt = 0;
            end
            if (t1) begin
                m_e   = (m_a / (2 ** (W - 2))) % 2;
                m_a   = (m_a + 1) % (2 ** W);
                m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            end
            if (t2) begin
                m_done = (m_f == 0) ? 1 : 0;
                m_f    = 1;
            end
        end
    endtask

    task automatic do_reset();
        #2;
        RST = 1'b1;
        model_reset();
        #1;
        chk_all("reset_async", 0, 0, 0, 0, 0, 0);
        @(posedge CLK);
        #2;
        RST = 1'b0;
    endtask

    task automatic run_t1(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    vec_t tbl[15];

    initial begin
        RST = 1'b0; S = 1'b0; T0 = 1'b0; T1 = 1'b0; T2 = 1'b0; ERR_CLR = 1'b0;
        model_reset();

        //             t0 t1 t2 s clr   A  E  F  D Er CNT
        tbl[0]  = '{1, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 1};
        tbl[2]  = '{0, 1, 0, 0, 0,   2, 0, 0, 0, 0, 2};
        tbl[3]  = '{0, 1, 0, 0, 0,   3, 0, 0, 0, 0, 3};
        tbl[4]  = '{0, 1, 0, 0, 0,   4, 0, 0, 0, 0, 4};
        tbl[5]  = '{0, 1, 0, 0, 0,   5, 1, 0, 0, 0, 5};
        tbl[6]  = '{0, 0, 0, 1, 0,   5, 1, 0, 0, 0, 5};
        tbl[7]  = '{1, 0, 0, 0, 0,   5, 1, 0, 0, 0, 5};
        tbl[8]  = '{0, 0, 1, 0, 0,   5, 1, 1, 1, 0, 5};
        tbl[9]  = '{0, 0, 1, 0, 0,   5, 1, 1, 0, 0, 5};
        tbl[10] = '{1, 0, 1, 1, 0,   5, 1, 1, 0, 1, 5};
        tbl[11] = '{0, 1, 0, 0, 0,   6, 1, 1, 0, 1, 6};
        tbl[12] = '{0, 0, 0, 0, 1,   6, 1, 1, 0, 0, 6};
        tbl[13] = '{1, 0, 0, 1, 0,   0, 1, 0, 0, 0, 0};
        tbl[14] = '{0, 0, 1, 0, 0,   0, 1, 1, 1, 0, 0};

        do_reset();
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].t0, tbl[i].t1, tbl[i].t2, tbl[i].s, tbl[i].clr);
            chk_all($sformatf("vec%0d", i), tbl[i].a, tbl[i].e, tbl[i].f, tbl[i].done,
                    tbl[i].err, tbl[i].cnt);
        end

        // Start, 12 increments, then T2 held two cycles
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        run_t1(12);
        chk_all("count12", 12, 0, 0, 0, 0, 12);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("t2_first", 12, 0, 1, 1, 0, 12);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("t2_second", 12, 0, 1, 0, 0, 12);

        // Wrap from all-ones
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        run_t1(15);
        chk_all("at15", 15, 1, 0, 0, 0, 15);
        run_t1(1);
        chk_all("wrap", 0, 1, 0, 0, 0, 16);

        // Illegal control and ERR clear priority
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        run_t1(5);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("illegal_t0t1", 5, 1, 0, 0, 1, 5);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_all("err_clr", 5, 1, 0, 0, 0, 5);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk_all("illegal_wins", 5, 1, 0, 0, 1, 5);

        // CNT saturation over a long count
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        run_t1(300);
        chk_all("sat300", 12, 0, 0, 0, 0, 255);

        // Asynchronous reset mid-count
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        run_t1(6);
        chk_all("at6", 6, 1, 0, 0, 0, 6);
        T1 = 1'b1;
        #2;
        RST = 1'b1;
        model_reset();
        #1;
        chk_all("rst_mid", 0, 0, 0, 0, 0, 0);
        @(posedge CLK);
        #1;
        chk_all("rst_held", 0, 0, 0, 0, 0, 0);
        RST = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_all("after_rst_hold", 0, 0, 0, 0, 0, 0);

        // Randomized control against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic t0, t1, t2, s, clr;
            r = $urandom_range(0, 9);
            t0 = 1'b0; t1 = 1'b0; t2 = 1'b0;
            s   = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 7) == 0);
            case (r)
                0, 1: t0 = 1'b1;
                2, 3, 4, 5: t1 = 1'b1;
                6: t2 = 1'b1;
                8: begin
                    t0 = 1'($urandom_range(0, 1));
                    t1 = 1'b1;
                    t2 = ~t0 | 1'($urandom_range(0, 1));
                end
                default: ;
            endcase
            step(t0, t1, t2, s, clr);
            chk_model($sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
